// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store access controller.
// Also holds the request legality check used at accept time.
package mem_access_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MREQ   = 2'd1,
      RDWAIT = 2'd2,
      RESP   = 2'd3
   } state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Illegal funct3 for the access direction, or an address not aligned to the access size.
   function automatic logic is_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
      logic legal;
      legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (!we) legal = legal || (f3 == F3_BU) || (f3 == F3_HU);
      if (!legal) return 1'b1;
      if (f3[1:0] == 2'b01) return off[0];
      if (f3[1:0] == 2'b10) return (off != 2'b00);
      return 1'b0;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_lane.sv
// Combinational lane steering for stores and byte/half extraction with extension for loads.
// Has no state; every output is a pure function of the latched request and the read word.
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   input  logic [31:0] st_data,
   input  logic [31:0] rd_word,
   output logic [31:0] wr_data,
   output logic [3:0]  wr_strb,
   output logic [31:0] ld_data
);

   logic [31:0] rd_shift;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign rd_shift = rd_word >> {offset, 3'b000};
   assign ld_byte  = rd_shift[7:0];
   assign ld_half  = offset[1] ? rd_word[31:16] : rd_word[15:0];

   always_comb begin
      wr_data = st_data;
      wr_strb = 4'b1111;
      case (funct3[1:0])
         2'b00: begin
            wr_data = {4{st_data[7:0]}};
            wr_strb = 4'b0001 << offset;
         end
         2'b01: begin
            wr_data = {2{st_data[15:0]}};
            wr_strb = offset[1] ? 4'b1100 : 4'b0011;
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_data = 32'd0;
      case (funct3)
         F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
         F3_W:    ld_data = rd_word;
         F3_BU:   ld_data = {24'd0, ld_byte};
         F3_HU:   ld_data = {16'd0, ld_half};
         default: ld_data = 32'd0;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencing controller between the core MEM stage and the data-memory bus.
// One request in flight at a time; response is held until the core consumes it.
//
// state  | meaning
// IDLE   | ready for a request from the core
// MREQ   | MemRead/MemWrite asserted, waiting for Mem_Req_Ready
// RDWAIT | load issued, waiting for Read_data_Valid
// RESP   | response presented, waiting for resp_ready
module mem_access_ctrl
   import mem_access_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] Address,
   output logic        MemWrite,
   output logic        MemRead,
   output logic [31:0] Write_data,
   output logic [3:0]  Write_strb,
   input  logic        Mem_Req_Ready,
   input  logic [31:0] Read_data,
   input  logic        Read_data_Valid,
   output logic        Read_data_Ready
);

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;

   logic [31:0] lane_wdata;
   logic [3:0]  lane_strb;
   logic [31:0] lane_ldata;

   mem_lane_align u_lane (
      .offset  (addr_q[1:0]),
      .funct3  (funct3_q),
      .st_data (wdata_q),
      .rd_word (Read_data),
      .wr_data (lane_wdata),
      .wr_strb (lane_strb),
      .ld_data (lane_ldata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         err_q    <= 1'b0;
         rdata_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      rdata_d  = rdata_q;

      req_ready       = 1'b0;
      resp_valid      = 1'b0;
      resp_rdata      = 32'd0;
      resp_err        = 1'b0;
      Address         = 32'd0;
      MemWrite        = 1'b0;
      MemRead         = 1'b0;
      Write_data      = 32'd0;
      Write_strb      = 4'd0;
      Read_data_Ready = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               err_d    = is_err(req_we, req_funct3, req_addr[1:0]);
               rdata_d  = 32'd0;
               state_d  = err_d ? RESP : MREQ;
            end
         end
         MREQ: begin
            MemRead  = ~we_q;
            MemWrite = we_q;
            Address  = {addr_q[31:2], 2'b00};
            // Store lanes only mean something on a write; keep the bus quiet for loads.
            if (we_q) begin
               Write_data = lane_wdata;
               Write_strb = lane_strb;
            end
            if (Mem_Req_Ready) state_d = we_q ? RESP : RDWAIT;
         end
         RDWAIT: begin
            Read_data_Ready = 1'b1;
            if (Read_data_Valid) begin
               rdata_d = lane_ldata;
               state_d = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            resp_rdata = rdata_q;
            resp_err   = err_q;
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a response scoreboard.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] Address, Write_data, Read_data;
   logic        MemWrite, MemRead, Mem_Req_Ready, Read_data_Valid, Read_data_Ready;
   logic [3:0]  Write_strb;

   int checks = 0;
   int errors = 0;
   logic [32:0] sb_q[$];

   always #5 clk = ~clk;

   mem_access_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .Address(Address), .MemWrite(MemWrite), .MemRead(MemRead),
      .Write_data(Write_data), .Write_strb(Write_strb),
      .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data),
      .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready)
   );

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drives one request on a negedge and steps the bus handshakes with the given stalls.
   task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rword,
                         input int mem_wait, input int rd_wait, input int resp_wait,
                         input logic exp_err, input logic [31:0] exp_rdata,
                         input logic [31:0] exp_wd, input logic [3:0] exp_strb);
      logic [32:0] exp;
      sb_q.push_back({exp_err, exp_rdata});
      chk("req_ready_idle", req_ready, 1);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
      if (exp_err) begin
         chk("err_no_memread", MemRead, 0);
         chk("err_no_memwrite", MemWrite, 0);
      end else begin
         // Stray read data while requesting must be ignored.
         Read_data_Valid = 1'b1; Read_data = 32'hDEAD_DEAD;
         for (int i = 0; i <= mem_wait; i++) begin
            chk("memread", MemRead, !we);
            chk("memwrite", MemWrite, we);
            chk("address", Address, {addr[31:2], 2'b00});
            chk("req_ready_busy", req_ready, 0);
            if (we) begin
               chk("write_data", Write_data, exp_wd);
               chk("write_strb", Write_strb, exp_strb);
            end
            if (i == mem_wait) Mem_Req_Ready = 1'b1;
            @(negedge clk);
         end
         Mem_Req_Ready = 1'b0; Read_data_Valid = 1'b0;
         if (!we) begin
            for (int i = 0; i < rd_wait; i++) begin
               chk("rd_ready_wait", Read_data_Ready, 1);
               chk("memread_drop", MemRead, 0);
               chk("resp_valid_early", resp_valid, 0);
               @(negedge clk);
            end
            chk("rd_ready", Read_data_Ready, 1);
            Read_data = rword; Read_data_Valid = 1'b1;
            @(negedge clk);
            Read_data_Valid = 1'b0; Read_data = 32'h1357_9BDF;
         end
      end
      exp = sb_q.pop_front();
      for (int i = 0; i <= resp_wait; i++) begin
         chk("resp_valid", resp_valid, 1);
         chk("req_ready_resp", req_ready, 0);
         chk("resp_rdata", resp_rdata, exp[31:0]);
         chk("resp_err", resp_err, exp[32]);
         chk("memread_resp", MemRead, 0);
         if (i == resp_wait) resp_ready = 1'b1;
         @(negedge clk);
      end
      resp_ready = 1'b0;
      chk("resp_valid_done", resp_valid, 0);
      chk("req_ready_done", req_ready, 1);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
      Mem_Req_Ready = 1'b0; Read_data = 32'd0; Read_data_Valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_address", Address, 0);
      chk("rst_resp_rdata", resp_rdata, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_memread", MemRead, 0);
      chk("rst_memwrite", MemWrite, 0);
      chk("rst_rd_ready", Read_data_Ready, 0);
      chk("rst_strb", Write_strb, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // LB 0x103: top byte 0x80 sign-extended
      run_op(0, 3'b000, 32'h103, 0, 32'h80FF_1234, 0, 0, 0, 0, 32'hFFFF_FF80, 0, 0);
      // LHU / LH at 0x202
      run_op(0, 3'b101, 32'h202, 0, 32'hBEEF_0001, 0, 0, 0, 0, 32'h0000_BEEF, 0, 0);
      run_op(0, 3'b001, 32'h202, 0, 32'hBEEF_0001, 0, 0, 0, 0, 32'hFFFF_BEEF, 0, 0);
      // SB 0x301 with memory stalled 3 cycles
      run_op(1, 3'b000, 32'h301, 32'h0000_00A5, 0, 3, 0, 0, 0, 0, 32'hA5A5_A5A5, 4'b0010);
      // Misaligned LW
      run_op(0, 3'b010, 32'h402, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      // Late read data and held-off response
      run_op(0, 3'b010, 32'h0, 0, 32'h1234_5678, 0, 5, 2, 0, 32'h1234_5678, 0, 0);
      // SH upper half, SW, LBU lane 1
      run_op(1, 3'b001, 32'h206, 32'h1234_ABCD, 0, 1, 0, 0, 0, 0, 32'hABCD_ABCD, 4'b1100);
      run_op(1, 3'b010, 32'h10, 32'hCAFE_F00D, 0, 0, 0, 1, 0, 0, 32'hCAFE_F00D, 4'b1111);
      run_op(0, 3'b100, 32'h101, 0, 32'h0000_8000, 0, 0, 0, 0, 32'h0000_0080, 0, 0);
      // Illegal funct3 and misaligned store
      run_op(0, 3'b011, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      run_op(1, 3'b100, 32'h0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      run_op(1, 3'b001, 32'h1, 0, 0, 0, 0, 0, 1, 0, 0, 0);

      // Reset during RDWAIT
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0;
      @(negedge clk);
      req_valid = 1'b0; Mem_Req_Ready = 1'b1;
      @(negedge clk);
      Mem_Req_Ready = 1'b0;
      chk("rdwait_before_rst", Read_data_Ready, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_rd_ready", Read_data_Ready, 0);
      chk("rst_mid_memread", MemRead, 0);
      chk("rst_mid_req_ready", req_ready, 1);
      chk("rst_mid_resp_valid", resp_valid, 0);
      @(negedge clk);
      chk("rst_mid_resp_valid2", resp_valid, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_resp_valid", resp_valid, 0);
      run_op(0, 3'b010, 32'h0, 0, 32'h0BAD_F00D, 0, 0, 0, 0, 32'h0BAD_F00D, 0, 0);

      chk("scoreboard_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
